// File: rtl/seq_matvec_pkg.sv
// seq_matvec_pkg: shared FSM states and width helpers for the sequential matrix-vector MAC
package seq_matvec_pkg;
  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic bit ow_ok(input int n, input int dim, input int ow);
    return (dim >= 2) && (ow >= 2 * n + clog2(dim) + 1);
  endfunction
endpackage

// File: rtl/seq_matvec_mac_mac.sv
// mac_acc_unit: signed multiply-accumulate with per-row clear and registered sum
module mac_acc_unit #(
  parameter int N  = 16,
  parameter int OW = 2 * N + 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [N-1:0]  a,
  input  logic signed [N-1:0]  b,
  output logic signed [OW-1:0] acc
);
  logic signed [2*N-1:0] prod;
  logic [OW-1:0] acc_q, acc_d;
  always_comb begin
    prod = a * b;
    acc_d = en ? (clr ? '0 : acc_q) + {{(OW-2*N){prod[2*N-1]}}, prod} : acc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/seq_matvec_mac.sv
// seq_matvec_mac: y = A*x over a stream, one shared MAC, optional resident-matrix reuse
module seq_matvec_mac
  import seq_matvec_pkg::*;
#(
  parameter int N   = 16,
  parameter int DIM = 4,
  parameter int OW  = 2 * N + 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [N-1:0]  in_data,
  input  logic                 reuse_mat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);
  localparam int MM = DIM * DIM;
  localparam int JB = MM + DIM;
  localparam int LW = clog2(JB);
  localparam int CW = clog2(DIM);
  localparam int RW = clog2(DIM + 1);
  if (!ow_ok(N, DIM, OW)) begin : g_bad_cfg
    $error("seq_matvec_mac: OW too small or DIM < 2");
  end
  state_e st_q, st_d;
  logic [LW-1:0] ld_q, ld_d, eff;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d, k_q, k_d;
  logic mv_q, mv_d, rdy_q, take, acc_en, acc_clr;
  logic signed [N-1:0] mat_q [MM], mat_d [MM], x_q [DIM], x_d [DIM], a_op, b_op;
  logic signed [OW-1:0] y_q [DIM], y_d [DIM], acc;
  mac_acc_unit #(.N(N), .OW(OW)) u_mac (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .en(acc_en), .a(a_op), .b(b_op), .acc(acc)
  );
  assign in_ready = rdy_q && st_q == LOAD;
  assign take = in_valid && in_ready;
  assign out_valid = st_q == OUTPUT;
  assign out_last = out_valid && k_q == CW'(DIM - 1);
  assign busy = st_q != LOAD || ld_q != '0;
  // A reuse job jumps straight to the first x slot of the beat index space
  assign eff = (ld_q == '0 && reuse_mat && mv_q) ? LW'(MM) : ld_q;
  always_comb begin
    st_d = st_q;
    ld_d = ld_q;
    r_d = r_q;
    c_d = c_q;
    k_d = k_q;
    mv_d = mv_q;
    mat_d = mat_q;
    x_d = x_q;
    y_d = y_q;
    a_op = '0;
    b_op = '0;
    out_data = '0;
    for (int i = 0; i < MM; i++) if (r_q == RW'(i / DIM) && c_q == CW'(i % DIM)) a_op = mat_q[i];
    for (int i = 0; i < DIM; i++) if (c_q == CW'(i)) b_op = x_q[i];
    for (int i = 0; i < DIM; i++) if (out_valid && k_q == CW'(i)) out_data = y_q[i];
    acc_en = st_q == COMPUTE && r_q != RW'(DIM);
    acc_clr = c_q == '0;
    case (st_q)
      LOAD: if (take) begin
        for (int i = 0; i < MM; i++) if (eff == LW'(i)) mat_d[i] = in_data;
        for (int i = 0; i < DIM; i++) if (eff == LW'(MM + i)) x_d[i] = in_data;
        ld_d = eff + 1'b1;
        if (eff == LW'(JB - 1)) begin
          ld_d = '0;
          mv_d = 1'b1;
          r_d = '0;
          c_d = '0;
          st_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // The registered row sum is visible one cycle after its last product
        for (int i = 0; i < DIM; i++) if (c_q == '0 && r_q == RW'(i + 1)) y_d[i] = acc;
        if (r_q == RW'(DIM)) begin
          st_d = OUTPUT;
          k_d = '0;
        end else if (c_q == CW'(DIM - 1)) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else c_d = c_q + 1'b1;
      end
      OUTPUT: if (out_ready) begin
        k_d = k_q + 1'b1;
        if (k_q == CW'(DIM - 1)) begin
          k_d = '0;
          st_d = LOAD;
        end
      end
      default: st_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= LOAD;
      ld_q <= '0;
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
      mv_q <= 1'b0;
      rdy_q <= 1'b0;
      mat_q <= '{default: '0};
      x_q <= '{default: '0};
      y_q <= '{default: '0};
    end else begin
      st_q <= st_d;
      ld_q <= ld_d;
      r_q <= r_d;
      c_q <= c_d;
      k_q <= k_d;
      mv_q <= mv_d;
      rdy_q <= 1'b1;
      mat_q <= mat_d;
      x_q <= x_d;
      y_q <= y_d;
    end
endmodule

// File: doc/seq_matvec_mac.md
Name: seq_matvec_mac

Overview:
- Sequential signed matrix-vector multiplier: y = A·x, A is DIM×DIM, x is DIM×1, elements N-bit signed.
- Uses one shared signed multiply-accumulate unit instead of DIM² parallel MACs. Accumulates one product per cycle.
- Operands arrive on a valid/ready input stream; results leave on a valid/ready output stream.
- Optional matrix-reuse mode keeps A resident, so follow-on jobs stream only a new x. Sits between a sample source and downstream filter/transform stages.

Parameters:
- N, 16, operand width (signed two's complement)
- DIM, 4, matrix/vector dimension (≥2)
- OW, 2*N+3, result width; must be ≥ 2*N+clog2(DIM)+1 (elaboration error otherwise)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts input beat
- in_data  in  N  operand: A row-major then x, or x only in reuse mode
- reuse_mat  in  1  sampled on first accepted beat of a job; 1 = keep stored A
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OW  result element y[k], signed
- out_last  out  1  high with y[DIM-1]
- busy  out  1  high in COMPUTE or OUTPUT, or in LOAD after the first beat of a job

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - in_ready=0 during reset, then 1 from the first clock edge after deassertion.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - All storage, counters and mat_valid cleared; state=LOAD.
- FSM states: LOAD, COMPUTE, OUTPUT.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid&&in_ready.
  - A full job is DIM*DIM A beats (row-major, a[r][c]) then DIM x beats.
  - If reuse_mat=1 on the job's first beat and mat_valid=1, the job is DIM x beats only and A is unchanged.
  - If reuse_mat=1 but mat_valid=0, reuse_mat is ignored and a full load is expected.
  - reuse_mat is ignored on all later beats of a job.
  - Gaps in in_valid are allowed; counters hold.
  - On acceptance of the final beat: state→COMPUTE; mat_valid←1 on a full load.
- COMPUTE:
  - in_ready=0. Runs exactly DIM*DIM cycles; cycle (r,c) computes acc ← (c==0 ? 0 : acc) + sext(a[r][c]*x[c]).
  - The product is a full 2N-bit signed result, sign-extended to OW. No overflow can occur given the OW constraint.
  - At c==DIM-1, the row sum is written to y[r].
  - After the last cycle: state→OUTPUT with out_valid=1 on the next edge.
- Latency: out_valid rises DIM*DIM+1 cycles after the edge that accepts the final input beat (17 for DIM=4).
- OUTPUT:
  - out_valid=1; out_data=y[k], starting at k=0; out_last=(k==DIM-1).
  - k advances on out_valid&&out_ready. While out_ready=0, out_data and out_last hold stable.
  - The handshake on k=DIM-1 returns state to LOAD; out_valid and busy fall on that edge and in_ready rises on it.
  - No overlap between input and output phases.
- Reset mid-job (any state): immediate abort. All state is cleared, including mat_valid, so the next job must be a full load.

Decomposition:
- Shared package seq_matvec_pkg:
  - state enum {LOAD, COMPUTE, OUTPUT}
  - clog2 helper, ACC width check constant
  - index width constants derived from DIM
- One natural sub-module: mac_acc_unit (N-bit signed A/B, OW-bit accumulator, clear and enable inputs, registered output).
- Operand storage (DIM²+DIM registers) and the FSM live in seq_matvec_mac.

Test Plan (DIM=4, N=16, OW=35):
- Identity A, x=1,2,3,4, out_ready=1 → outputs 1,2,3,4; out_last on 4th; first out_valid 17 cycles after the last input accept.
- All a=-32768, x=-32768 → each y=4294967296 (no wrap); a[0][*]=32767 with x=-32768 → y[0]=-4294836224.
- Back-pressure: out_ready low 5 cycles at k=1 → out_data holds y[1] and out_valid stays 1; sequence completes unchanged.
- Reuse: after the identity job, reuse_mat=1 with x=5,6,7,8 → exactly 4 beats accepted, outputs 5,6,7,8. reuse_mat=1 right after reset → treated as full 20-beat load.
- Input gaps: in_valid toggled 1/0 each cycle → same results as the gapless case; in_ready=0 throughout COMPUTE.
- rst_n pulsed low mid-COMPUTE → outputs zero immediately, state LOAD, mat_valid cleared; the following reuse request requires a full load.
